pipe_barrel_shifter: RTL and testbench



---
 rtl/alu_shift_pkg.sv | 16 +
 rtl/shift_stage.sv | 29 ++
 rtl/pipe_barrel_shifter.sv | 86 ++++++++
 tb/tb_pipe_barrel_shifter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU32 shift datapath: operation encoding and
// the shift-amount width derived from the data width.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log step of the barrel shifter: shifts or rotates by DIST when en is
// set, otherwise passes the operand through unchanged.
module shift_stage
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] shifted
);

  // NOTE: the pass-through default is assigned before any branch so every
  // path through this block drives 'shifted' and no latch is inferred.
  always_comb begin
    shifted = data;
    if (en) begin
      unique case (sh_op_e'(op))
        SH_SLL: shifted = data << DIST;
        SH_SRL: shifted = data >> DIST;
        SH_SRA: shifted = $signed(data) >>> DIST;
        SH_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on
// both sides; the whole pipe freezes while the output is back-pressured.
module pipe_barrel_shifter
  import alu_shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAGW  = 4,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag
);

  // Rank 0 captures the accepted operation; rank k+1 holds the result of
  // log stage k, so the last rank is the output register.
  localparam int NR = SHW + 1;

  logic [NR-1:0]    st_valid;
  logic [WIDTH-1:0] st_data [NR];
  logic [TAGW-1:0]  st_tag  [NR];
  logic [1:0]       st_op   [SHW];
  logic [SHW-1:0]   st_amt  [SHW];
  logic [WIDTH-1:0] shifted [SHW];
  logic             stall;

  assign stall     = st_valid[SHW] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = st_valid[SHW];
  assign out_data  = st_data[SHW];
  assign out_tag   = st_tag[SHW];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .data    (st_data[k]),
      .en      (st_amt[k][k]),
      .op      (st_op[k]),
      .shifted (shifted[k])
    );
  end

  // NOTE: every pipeline array is cleared in the async reset branch, not only
  // the valid bits, so in-flight operations vanish and outputs read zero.
  // NOTE: state is updated with <= so all ranks advance from the pre-edge
  // values of their predecessors, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int k = 0; k < NR; k++) begin
        st_data[k] <= '0;
        st_tag[k]  <= '0;
      end
      for (int k = 0; k < SHW; k++) begin
        st_op[k]  <= '0;
        st_amt[k] <= '0;
      end
    end else if (!stall) begin
      st_valid   <= {st_valid[NR-2:0], in_valid};
      st_data[0] <= in_data;
      st_tag[0]  <= in_tag;
      st_op[0]   <= in_op;
      st_amt[0]  <= in_amt;
      for (int k = 0; k < SHW; k++) begin
        st_data[k+1] <= shifted[k];
        st_tag[k+1]  <= st_tag[k];
      end
      for (int k = 0; k + 1 < SHW; k++) begin
        st_op[k+1]  <= st_op[k];
        st_amt[k+1] <= st_amt[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Scoreboard bench for pipe_barrel_shifter: directed cases, backpressure and
// reset on a 32-bit instance, plus a randomized sweep on an 8-bit instance.
module tb_pipe_barrel_shifter;
  import alu_shift_pkg::*;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 32-bit instance
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  pipe_barrel_shifter #(.WIDTH(32), .TAGW(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  // 8-bit instance
  logic       b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_in_amt;
  logic [1:0] b_in_op;
  logic [3:0] b_in_tag, b_out_tag;

  pipe_barrel_shifter #(.WIDTH(8), .TAGW(4)) u_dut8 (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_amt(b_in_amt), .in_op(b_in_op), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  bit   done8 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference: the mode rules applied as whole-word arithmetic on w bits.
  function automatic logic [63:0] model(input logic [63:0] d_in, input int a, input int op, input int w);
    logic [63:0] mask, d, r;
    mask = (64'd1 << w) - 64'd1;
    d    = d_in & mask;
    case (op)
      0:       r = d << a;
      1:       r = d >> a;
      2:       r = (d >> a) | (d[w-1] ? (mask & ~(mask >> a)) : 64'd0);
      default: r = (d >> a) | (d << (w - a));
    endcase
    return r & mask;
  endfunction

  // Monitors: compare on every transfer; while stalled the held output must
  // already be the oldest outstanding expectation and in_ready must be low.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected32: actual data %0h tag %0h required none", out_data, out_tag);
      end else if (!out_ready) begin
        check("stall32_in_ready", in_ready, 0);
        check("stall32_data", out_data, q32[0].data);
        check("stall32_tag", out_tag, q32[0].tag);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("out32_data", out_data, e.data);
        check("out32_tag", out_tag, e.tag);
        if (e.lat) check("latency32", cyc - e.acc, 5);
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_out_valid) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected8: actual data %0h tag %0h required none", b_out_data, b_out_tag);
      end else if (!b_out_ready) begin
        check("stall8_in_ready", b_in_ready, 0);
        check("stall8_data", b_out_data, q8[0].data);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("out8_data", b_out_data, e.data);
        check("out8_tag", b_out_tag, e.tag);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue32(input logic [31:0] d, input logic [4:0] a, input logic [1:0] o,
                         input logic [3:0] t, input logic [31:0] e, input bit lat);
    int n;
    exp_t x;
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = o; in_tag = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      check("accept32_timeout", in_ready, 1);
    end else begin
      x.data = e; x.tag = t; x.lat = lat; x.acc = cyc + 1;
      q32.push_back(x);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o,
                        input logic [3:0] t, input logic [7:0] e);
    int n;
    exp_t x;
    b_in_valid = 1'b1; b_in_data = d; b_in_amt = a; b_in_op = o; b_in_tag = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_in_ready && n < 200);
    if (!b_in_ready) begin
      check("accept8_timeout", b_in_ready, 1);
    end else begin
      x.data = {24'd0, e}; x.tag = t; x.lat = 0; x.acc = cyc + 1;
      q8.push_back(x);
    end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  task automatic drain32(input string name);
    int n = 0;
    while ((q32.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1 check(name, q32.size(), 0);
  endtask

  initial begin : main32
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  o;
    int          n;
    bit          rdone;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_in_ready", in_ready, 1);

    // Directed cases with an empty pipe so latency can be measured.
    issue32(32'h0000_0001, 5'd31, SH_SLL, 4'd3, 32'h8000_0000, 1);
    drain32("drain_sll");
    issue32(32'h8000_0000, 5'd4, SH_SRA, 4'd4, 32'hF800_0000, 1);
    issue32(32'h8000_0000, 5'd4, SH_SRL, 4'd5, 32'h0800_0000, 0);
    issue32(32'h1234_5678, 5'd8, SH_ROR, 4'd6, 32'h7812_3456, 0);
    drain32("drain_modes");
    issue32(32'hF000_000F, 5'd0, SH_SLL, 4'd1, 32'hF000_000F, 1);
    issue32(32'hF000_000F, 5'd0, SH_SLL, 4'd2, 32'hF000_000F, 1);
    drain32("drain_b2b");

    // Backpressure: three stalled cycles once results start to emerge.
    fork
      for (int i = 0; i < 6; i++) begin
        d = $urandom(); a = 5'($urandom()); o = 2'($urandom());
        issue32(d, a, o, 4'(i), model({32'd0, d}, a, o, 32)[31:0], 0);
      end
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain32("drain_backpressure");

    // Reset with three results piled up behind a stalled output.
    #1 out_ready = 1'b0;
    issue32(32'hAAAA_5555, 5'd1, SH_SLL, 4'd9, 32'h5554_AAAA, 0);
    issue32(32'hAAAA_5555, 5'd2, SH_ROR, 4'd10, 32'h6AAA_9555, 0);
    issue32(32'hAAAA_5555, 5'd3, SH_SRA, 4'd11, 32'hF555_4AAA, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_valid", out_valid, 0);
    check("async_reset_data", out_data, 0);
    q32.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("post_reset_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1 check("no_stale_result", out_valid, 0);

    // Randomized sweep with bubbles and random backpressure.
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          d = $urandom(); a = 5'($urandom()); o = 2'($urandom());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          issue32(d, a, o, 4'($urandom()), model({32'd0, d}, a, o, 32)[31:0], 0);
        end
        rdone = 1;
      end
      while (!rdone) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    out_ready = 1'b1;
    drain32("drain_random32");

    n = 0;
    while (!done8 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("sweep8_done", done8, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // 8-bit sweep: every mode and amount, several operands each, random stalls.
  initial begin : main8
    logic [7:0] d;
    int         n;
    bit         sdone;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_op = '0;
    b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 b_rst_n = 1'b1;
    sdone = 0;
    fork
      begin
        for (int op = 0; op < 4; op++)
          for (int a = 0; a < 8; a++)
            for (int r = 0; r < 4; r++) begin
              d = 8'($urandom());
              if (r == 0) d = 8'h81;
              issue8(d, 3'(a), 2'(op), 4'($urandom()), model({56'd0, d}, a, op, 8)[7:0]);
            end
        sdone = 1;
      end
      while (!sdone) begin
        @(posedge clk);
        #1 b_out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    b_out_ready = 1'b1;
    n = 0;
    while ((q8.size() != 0 || b_out_valid) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain_random8", q8.size(), 0);
    done8 = 1;
  end

endmodule
